// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - state, opcode, funct and select encodings for the multi-cycle control FSM
package mc_defs;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_IEXEC  = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BEQ    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [2:0] SRCB_REGB   = 3'b000;
    localparam logic [2:0] SRCB_FOUR   = 3'b001;
    localparam logic [2:0] SRCB_SIMM   = 3'b010;
    localparam logic [2:0] SRCB_SIMM2  = 3'b011;
    localparam logic [2:0] SRCB_ZIMM   = 3'b100;
    localparam logic [2:0] SRCB_IMMHI  = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_alu_decode.sv
// rtl/multi_cycle_ctrl_alu_decode.sv - R-type funct to ALUControl decode
module mc_alu_decode
    import mc_defs::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctl,
    output logic       o_valid
);

    // Map supported ALU functs; o_valid flags whether funct is one of them.
    always_comb begin
        o_alu_ctl = ALU_ADD;
        o_valid   = 1'b1;
        case (i_funct)
            FN_ADDU: o_alu_ctl = ALU_ADD;
            FN_SUBU: o_alu_ctl = ALU_SUB;
            FN_AND:  o_alu_ctl = ALU_AND;
            FN_OR:   o_alu_ctl = ALU_OR;
            FN_SLT:  o_alu_ctl = ALU_SLT;
            default: o_valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS control FSM with wait-state memory handshake
module multi_cycle_ctrl
    import mc_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WBSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [2:0] w_exec_ctl;
    logic       w_funct_alu;

    mc_alu_decode u_alu_decode (
        .i_funct   (funct),
        .o_alu_ctl (w_exec_ctl),
        .o_valid   (w_funct_alu)
    );

    assign state_dbg = r_state;

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state: memory states hold until mem_ready, DECODE dispatches on opcode/funct.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == FN_JR)    w_next = S_JR;
                        else if (w_funct_alu)  w_next = S_EXEC;
                        else                   w_next = S_FETCH;
                    end
                    OP_BEQ:         w_next = S_BEQ;
                    OP_ORI, OP_LUI: w_next = S_IEXEC;
                    OP_J:           w_next = S_JUMP;
                    OP_JAL:         w_next = S_JAL;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output decode per state; strobes are suppressed while reset is high so a
    // reset mid-access drops mem_req and never completes the write or IR load.
    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSource   = PCSRC_ALU;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        RegDst     = RDST_RT;
        WBSrc      = WB_ALUOUT;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_SIMM2;
                if (opcode == OP_RTYPE) begin
                    instr_done = (funct == FN_NOP);
                    illegal    = !w_funct_alu && (funct != FN_JR) && (funct != FN_NOP);
                end else begin
                    case (opcode)
                        OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_LUI, OP_J, OP_JAL: illegal = 1'b0;
                        default: illegal = 1'b1;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SIMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                WBSrc      = WB_MDR;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = w_exec_ctl;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = RDST_RD;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                if (opcode == OP_LUI) begin
                    ALUSrcB = SRCB_IMMHI;
                end else begin
                    ALUSrcB    = SRCB_ZIMM;
                    ALUControl = ALU_OR;
                end
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSource   = PCSRC_ALUOUT;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                RegWrite   = 1'b1;
                RegDst     = RDST_RA;
                WBSrc      = WB_PC;
                instr_done = 1'b1;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_REGA;
                instr_done = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_MEMADR = 4'd2, T_MEMRD = 4'd3,
                           T_MEMWB = 4'd4, T_MEMWR = 4'd5, T_EXEC = 4'd6, T_ALUWB = 4'd7,
                           T_IEXEC = 4'd8, T_IWB = 4'd9, T_BEQ = 4'd10, T_JUMP = 4'd11,
                           T_JAL = 4'd12, T_JR = 4'd14;

    typedef struct packed {
        logic       mem_req;
        logic       IorD;
        logic       MemWrite;
        logic       IRWrite;
        logic       PCWrite;
        logic [1:0] PCSource;
        logic       ALUSrcA;
        logic [2:0] ALUSrcB;
        logic [2:0] ALUControl;
        logic       RegWrite;
        logic [1:0] RegDst;
        logic [1:0] WBSrc;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic       chk;
        logic [3:0] st;
        outs_t      o;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite;
    logic       instr_done, illegal;
    logic [1:0] PCSource, RegDst, WBSrc;
    logic [2:0] ALUSrcB, ALUControl;
    logic [3:0] state_dbg;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    logic [5:0] cur_op, cur_fn;
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegWrite(RegWrite), .RegDst(RegDst),
        .WBSrc(WBSrc), .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic outs_t dflt();
        outs_t o;
        o = '0;
        o.ALUControl = 3'b010;
        return o;
    endfunction

    task automatic push(input logic chk, input logic rst, input logic rdy, input logic z,
                        input logic [3:0] st, input outs_t o);
        stim_q.push_back('{rst: rst, op: cur_op, fn: cur_fn, zero: z, rdy: rdy});
        exp_q.push_back('{chk: chk, st: st, o: o});
    endtask

    task automatic fetch(input int waits);
        outs_t o;
        o = dflt(); o.mem_req = 1'b1; o.ALUSrcB = 3'b001;
        for (int i = 0; i < waits; i++) push(1, 0, 0, 0, T_FETCH, o);
        o.IRWrite = 1'b1; o.PCWrite = 1'b1;
        push(1, 0, 1, 0, T_FETCH, o);
    endtask

    task automatic decode(input logic done, input logic ill);
        outs_t o;
        o = dflt(); o.ALUSrcB = 3'b011; o.instr_done = done; o.illegal = ill;
        push(1, 0, 0, 0, T_DECODE, o);
    endtask

    task automatic memadr();
        outs_t o;
        o = dflt(); o.ALUSrcA = 1'b1; o.ALUSrcB = 3'b010;
        push(1, 0, 0, 0, T_MEMADR, o);
    endtask

    task automatic do_lw(input int fw, input int rw);
        outs_t o;
        cur_op = 6'b100011; cur_fn = 6'h05;
        fetch(fw); decode(0, 0); memadr();
        o = dflt(); o.mem_req = 1'b1; o.IorD = 1'b1;
        for (int i = 0; i < rw; i++) push(1, 0, 0, 0, T_MEMRD, o);
        push(1, 0, 1, 0, T_MEMRD, o);
        o = dflt(); o.RegWrite = 1'b1; o.WBSrc = 2'b01; o.instr_done = 1'b1;
        push(1, 0, 0, 0, T_MEMWB, o);
    endtask

    task automatic do_sw(input int ww);
        outs_t o;
        cur_op = 6'b101011; cur_fn = 6'h11;
        fetch(0); decode(0, 0); memadr();
        o = dflt(); o.mem_req = 1'b1; o.IorD = 1'b1; o.MemWrite = 1'b1;
        for (int i = 0; i < ww; i++) push(1, 0, 0, 0, T_MEMWR, o);
        o.instr_done = 1'b1;
        push(1, 0, 1, 0, T_MEMWR, o);
    endtask

    task automatic do_rtype(input logic [5:0] fn, input logic [2:0] ctl);
        outs_t o;
        cur_op = 6'b000000; cur_fn = fn;
        fetch(0); decode(0, 0);
        o = dflt(); o.ALUSrcA = 1'b1; o.ALUControl = ctl;
        push(1, 0, 0, 0, T_EXEC, o);
        o = dflt(); o.RegWrite = 1'b1; o.RegDst = 2'b01; o.instr_done = 1'b1;
        push(1, 0, 0, 0, T_ALUWB, o);
    endtask

    task automatic do_imm(input logic lui);
        outs_t o;
        cur_op = lui ? 6'b001111 : 6'b001101; cur_fn = 6'h2a;
        fetch(0); decode(0, 0);
        o = dflt(); o.ALUSrcA = 1'b1;
        o.ALUSrcB = lui ? 3'b101 : 3'b100;
        o.ALUControl = lui ? 3'b010 : 3'b001;
        push(1, 0, 0, 0, T_IEXEC, o);
        o = dflt(); o.RegWrite = 1'b1; o.instr_done = 1'b1;
        push(1, 0, 0, 0, T_IWB, o);
    endtask

    task automatic do_beq(input logic z);
        outs_t o;
        cur_op = 6'b000100; cur_fn = 6'h00;
        fetch(0); decode(0, 0);
        o = dflt(); o.ALUSrcA = 1'b1; o.ALUControl = 3'b110; o.PCSource = 2'b01;
        o.PCWrite = z; o.instr_done = 1'b1;
        push(1, 0, 0, z, T_BEQ, o);
    endtask

    task automatic do_jump(input int kind);
        outs_t o;
        o = dflt(); o.PCWrite = 1'b1; o.instr_done = 1'b1;
        if (kind == 0) begin
            cur_op = 6'b000010; cur_fn = 6'h08;
            o.PCSource = 2'b10;
        end else if (kind == 1) begin
            cur_op = 6'b000011; cur_fn = 6'h00;
            o.PCSource = 2'b10; o.RegWrite = 1'b1; o.RegDst = 2'b10; o.WBSrc = 2'b10;
        end else begin
            cur_op = 6'b000000; cur_fn = 6'b001000;
            o.PCSource = 2'b11;
        end
        fetch(0); decode(0, 0);
        push(1, 0, 0, 0, (kind == 0) ? T_JUMP : (kind == 1) ? T_JAL : T_JR, o);
    endtask

    task automatic build();
        outs_t o;
        cur_op = 6'b0; cur_fn = 6'b0;
        o = dflt(); o.ALUSrcB = 3'b001;
        push(0, 1, 1, 0, T_FETCH, o);
        push(1, 1, 1, 0, T_FETCH, o);
        do_rtype(6'b100001, 3'b010);
        do_lw(2, 2);
        do_beq(1);
        do_beq(0);
        do_jump(1);
        do_jump(2);
        do_jump(0);
        cur_op = 6'b111111; cur_fn = 6'b100001;
        fetch(0); decode(0, 1);
        cur_op = 6'b000000; cur_fn = 6'b111111;
        fetch(1); decode(0, 1);
        cur_op = 6'b000000; cur_fn = 6'b000000;
        fetch(0); decode(1, 0);
        do_imm(0);
        do_imm(1);
        do_rtype(6'b100011, 3'b110);
        do_rtype(6'b100100, 3'b000);
        do_rtype(6'b100101, 3'b001);
        do_rtype(6'b101010, 3'b111);
        do_sw(1);
        do_lw(0, 0);
        cur_op = 6'b101011; cur_fn = 6'h11;
        fetch(0); decode(0, 0); memadr();
        o = dflt(); o.mem_req = 1'b1; o.IorD = 1'b1; o.MemWrite = 1'b1;
        push(1, 0, 0, 0, T_MEMWR, o);
        o = dflt(); o.IorD = 1'b1;
        push(1, 1, 1, 0, T_MEMWR, o);
        o = dflt(); o.mem_req = 1'b1; o.ALUSrcB = 3'b001;
        push(1, 0, 0, 0, T_FETCH, o);
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        build();
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset = s.rst; opcode = s.op; funct = s.fn; zero = s.zero; mem_ready = s.rdy;
            @(negedge clk);
            e = exp_q.pop_front();
            if (e.chk) begin
                check("state", {28'b0, state_dbg}, {28'b0, e.st});
                check("outs", {11'b0, mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSource,
                               ALUSrcA, ALUSrcB, ALUControl, RegWrite, RegDst, WBSrc,
                               instr_done, illegal}, {11'b0, e.o});
            end
            @(posedge clk);
            #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
